// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - opcode, select and FSM definitions shared by the hazard scoreboard
package hazard_pkg;

  localparam logic [4:0] OP_ALU  = 5'd0;
  localparam logic [4:0] OP_BNE  = 5'd2;
  localparam logic [4:0] OP_JAL  = 5'd3;
  localparam logic [4:0] OP_JR   = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_BLT  = 5'd6;
  localparam logic [4:0] OP_SW   = 5'd7;
  localparam logic [4:0] OP_LW   = 5'd8;
  localparam logic [4:0] OP_SETX = 5'd21;
  localparam logic [4:0] OP_BEX  = 5'd22;

  localparam logic [4:0] ALU_MUL = 5'd6;
  localparam logic [4:0] ALU_DIV = 5'd7;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_XM = 2'b01;
  localparam logic [1:0] FWD_MW = 2'b10;

  localparam int ST_FD = 0;
  localparam int ST_DX = 1;
  localparam int ST_XM = 2;
  localparam int ST_MW = 3;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  function automatic logic [4:0] instr_op(input logic [31:0] instr);
    return instr[31:27];
  endfunction

endpackage

// File: rtl/instr_operand_decode.sv
// rtl/instr_operand_decode.sv - destination and source register extraction for one pipeline stage
module instr_operand_decode
  import hazard_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int LINK_REG   = 31,
  parameter int STATUS_REG = 30
) (
  input  logic [31:0]      instr,
  input  logic             exception,
  output logic             dest_valid,
  output logic [REG_W-1:0] dest,
  output logic             src_a_valid,
  output logic [REG_W-1:0] src_a,
  output logic             src_b_valid,
  output logic [REG_W-1:0] src_b,
  output logic             src_st_valid,
  output logic [REG_W-1:0] src_st
);

  logic [4:0]       op;
  logic [REG_W-1:0] rd, rs, rt;
  logic             dest_hit, a_hit, b_hit, st_hit;
  logic             unused_bits;

  assign op          = instr_op(instr);
  assign rd          = instr[22 +: REG_W];
  assign rs          = instr[17 +: REG_W];
  assign rt          = instr[12 +: REG_W];
  assign unused_bits = ^instr[11:0];

  always_comb begin
    dest_hit = 1'b0;
    dest     = '0;
    a_hit    = 1'b0;
    src_a    = '0;
    b_hit    = 1'b0;
    src_b    = '0;
    st_hit   = 1'b0;
    src_st   = '0;
    case (op)
      OP_ALU: begin
        dest_hit = 1'b1; dest  = rd;
        a_hit    = 1'b1; src_a = rs;
        b_hit    = 1'b1; src_b = rt;
      end
      OP_ADDI, OP_LW: begin
        dest_hit = 1'b1; dest  = rd;
        a_hit    = 1'b1; src_a = rs;
      end
      OP_JAL:  begin dest_hit = 1'b1; dest = REG_W'(LINK_REG); end
      OP_SETX: begin dest_hit = 1'b1; dest = REG_W'(STATUS_REG); end
      OP_SW: begin
        a_hit  = 1'b1; src_a  = rs;
        st_hit = 1'b1; src_st = rd;
      end
      OP_BNE, OP_BLT: begin
        a_hit = 1'b1; src_a = rd;
        b_hit = 1'b1; src_b = rs;
      end
      OP_JR:  begin a_hit = 1'b1; src_a = rd; end
      OP_BEX: begin a_hit = 1'b1; src_a = REG_W'(STATUS_REG); end
      default: ;
    endcase
    // A faulting instruction writes the status register regardless of its opcode.
    if (exception) begin
      dest_hit = 1'b1;
      dest     = REG_W'(STATUS_REG);
    end
  end

  // Register 0 is hardwired, so it never produces or consumes a forwarded value.
  assign dest_valid   = dest_hit && (dest != '0);
  assign src_a_valid  = a_hit && (src_a != '0);
  assign src_b_valid  = b_hit && (src_b != '0);
  assign src_st_valid = st_hit && (src_st != '0);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - operand forwarding selects, load-use stall and mult/div busy control
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int LINK_REG   = 31,
  parameter int STATUS_REG = 30,
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] fd_instr,
  input  logic [31:0] dx_instr,
  input  logic [31:0] xm_instr,
  input  logic [31:0] mw_instr,
  input  logic        xm_exception,
  input  logic        mw_exception,
  input  logic        ctrl_flush,
  input  logic        multdiv_ready,
  output logic        multdiv_start,
  output logic        stall_front,
  output logic        stall_dx,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic [1:0]  fwd_st_sel,
  output logic        md_busy,
  output logic        md_timeout
);

  logic [31:0]      stage_instr [4];
  logic [3:0]       stage_exc;
  logic [3:0]       d_v, a_v, b_v, s_v;
  logic [REG_W-1:0] d_i [4];
  logic [REG_W-1:0] a_i [4];
  logic [REG_W-1:0] b_i [4];
  logic [REG_W-1:0] s_i [4];

  assign stage_instr[ST_FD] = fd_instr;
  assign stage_instr[ST_DX] = dx_instr;
  assign stage_instr[ST_XM] = xm_instr;
  assign stage_instr[ST_MW] = mw_instr;
  assign stage_exc          = {mw_exception, xm_exception, 2'b00};

  for (genvar g = 0; g < 4; g++) begin : g_stage
    instr_operand_decode #(
      .REG_W      (REG_W),
      .LINK_REG   (LINK_REG),
      .STATUS_REG (STATUS_REG)
    ) u_decode (
      .instr        (stage_instr[g]),
      .exception    (stage_exc[g]),
      .dest_valid   (d_v[g]),
      .dest         (d_i[g]),
      .src_a_valid  (a_v[g]),
      .src_a        (a_i[g]),
      .src_b_valid  (b_v[g]),
      .src_b        (b_i[g]),
      .src_st_valid (s_v[g]),
      .src_st       (s_i[g])
    );
  end

  logic unused_decode;
  assign unused_decode = ^{d_v[ST_FD], d_i[ST_FD], a_v[3:2], b_v[3:2], s_v[3:2],
                           a_i[ST_XM], a_i[ST_MW], b_i[ST_XM], b_i[ST_MW],
                           s_i[ST_XM], s_i[ST_MW]};

  // A load in X/M has no data yet; the load-use stall has already covered it.
  logic xm_fwd_valid;
  assign xm_fwd_valid = d_v[ST_XM] && (instr_op(xm_instr) != OP_LW);

  function automatic logic [1:0] pick_fwd(input logic v, input logic [REG_W-1:0] s,
                                          input logic xv, input logic [REG_W-1:0] xd,
                                          input logic mv, input logic [REG_W-1:0] md);
    if (v && xv && (s == xd)) return FWD_XM;
    if (v && mv && (s == md)) return FWD_MW;
    return FWD_RF;
  endfunction

  logic [1:0] fwd_a_raw, fwd_b_raw, fwd_st_raw;
  assign fwd_a_raw  = pick_fwd(a_v[ST_DX], a_i[ST_DX], xm_fwd_valid, d_i[ST_XM], d_v[ST_MW], d_i[ST_MW]);
  assign fwd_b_raw  = pick_fwd(b_v[ST_DX], b_i[ST_DX], xm_fwd_valid, d_i[ST_XM], d_v[ST_MW], d_i[ST_MW]);
  assign fwd_st_raw = pick_fwd(s_v[ST_DX], s_i[ST_DX], xm_fwd_valid, d_i[ST_XM], d_v[ST_MW], d_i[ST_MW]);

  logic fd_uses_dx, load_use;
  assign fd_uses_dx = (a_v[ST_FD] && (a_i[ST_FD] == d_i[ST_DX])) ||
                      (b_v[ST_FD] && (b_i[ST_FD] == d_i[ST_DX])) ||
                      (s_v[ST_FD] && (s_i[ST_FD] == d_i[ST_DX]));
  assign load_use   = (instr_op(dx_instr) == OP_LW) && d_v[ST_DX] && fd_uses_dx && !ctrl_flush;

  logic dx_is_md;
  assign dx_is_md = (instr_op(dx_instr) == OP_ALU) &&
                    ((dx_instr[6:2] == ALU_MUL) || (dx_instr[6:2] == ALU_DIV));

  md_state_t        state;
  logic [CNT_W-1:0] busy_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= MD_IDLE;
      busy_cnt      <= '0;
      multdiv_start <= 1'b0;
      md_timeout    <= 1'b0;
    end else begin
      multdiv_start <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (dx_is_md && !ctrl_flush) begin
            state         <= MD_BUSY;
            busy_cnt      <= '0;
            multdiv_start <= 1'b1;
          end
        end
        MD_BUSY: begin
          busy_cnt <= busy_cnt + 1'b1;
          if (multdiv_ready) begin
            state <= MD_DONE;
          end else if (busy_cnt == CNT_W'(MD_TIMEOUT - 1)) begin
            md_timeout <= 1'b1;
            busy_cnt   <= '0;
            state      <= MD_IDLE;
          end
        end
        MD_DONE: begin
          busy_cnt <= '0;
          state    <= MD_IDLE;
        end
        default: begin
          busy_cnt <= '0;
          state    <= MD_IDLE;
        end
      endcase
    end
  end

  assign md_busy     = (state == MD_BUSY);
  assign stall_dx    = md_busy;
  assign stall_front = reset_n && (load_use || md_busy);
  assign fwd_a_sel   = reset_n ? fwd_a_raw  : FWD_RF;
  assign fwd_b_sel   = reset_n ? fwd_b_raw  : FWD_RF;
  assign fwd_st_sel  = reset_n ? fwd_st_raw : FWD_RF;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb/tb_hazard_scoreboard_unit.sv - self-checking bench for hazard_scoreboard_unit
module tb_hazard_scoreboard_unit;

  logic        clock, reset_n;
  logic [31:0] fd_instr, dx_instr, xm_instr, mw_instr;
  logic        xm_exception, mw_exception, ctrl_flush, multdiv_ready;
  logic        multdiv_start, stall_front, stall_dx, md_busy, md_timeout;
  logic [1:0]  fwd_a_sel, fwd_b_sel, fwd_st_sel;

  int n_chk  = 0;
  int n_fail = 0;

  hazard_scoreboard_unit dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .fd_instr      (fd_instr),
    .dx_instr      (dx_instr),
    .xm_instr      (xm_instr),
    .mw_instr      (mw_instr),
    .xm_exception  (xm_exception),
    .mw_exception  (mw_exception),
    .ctrl_flush    (ctrl_flush),
    .multdiv_ready (multdiv_ready),
    .multdiv_start (multdiv_start),
    .stall_front   (stall_front),
    .stall_dx      (stall_dx),
    .fwd_a_sel     (fwd_a_sel),
    .fwd_b_sel     (fwd_b_sel),
    .fwd_st_sel    (fwd_st_sel),
    .md_busy       (md_busy),
    .md_timeout    (md_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ins(input int op, input int rd, input int rs, input int rt, input int alu);
    return {5'(op), 5'(rd), 5'(rs), 5'(rt), 5'd0, 5'(alu), 2'd0};
  endfunction

  localparam logic [31:0] NOP = 32'd0;

  // Reference model: register usage straight from the ISA table.
  function automatic int m_dest(input logic [31:0] i, input logic exc);
    int op, d;
    op = int'(i[31:27]);
    d  = -1;
    if (exc) d = 30;
    else if (op == 0 || op == 5 || op == 8) d = int'(i[26:22]);
    else if (op == 3) d = 31;
    else if (op == 21) d = 30;
    return (d == 0) ? -1 : d;
  endfunction

  function automatic int m_src(input logic [31:0] i, input int k);
    int op, rd, rs, rt;
    int s [3];
    op = int'(i[31:27]); rd = int'(i[26:22]); rs = int'(i[21:17]); rt = int'(i[16:12]);
    s = '{-1, -1, -1};
    case (op)
      0:       s = '{rs, rt, -1};
      5, 8:    s = '{rs, -1, -1};
      7:       s = '{rs, -1, rd};
      2, 6:    s = '{rd, rs, -1};
      4:       s = '{rd, -1, -1};
      22:      s = '{30, -1, -1};
      default: ;
    endcase
    return (s[k] == 0) ? -1 : s[k];
  endfunction

  function automatic int m_fwd(input int k);
    int s;
    s = m_src(dx_instr, k);
    if (s < 0) return 0;
    if (xm_instr[31:27] != 5'd8 && m_dest(xm_instr, xm_exception) == s) return 1;
    if (m_dest(mw_instr, mw_exception) == s) return 2;
    return 0;
  endfunction

  function automatic int m_load_use();
    int rd;
    rd = int'(dx_instr[26:22]);
    if (dx_instr[31:27] != 5'd8 || rd == 0 || ctrl_flush) return 0;
    for (int k = 0; k < 3; k++)
      if (m_src(fd_instr, k) == rd) return 1;
    return 0;
  endfunction

  // Mult/div unit model: 0 idle, 1 busy, 2 done; m_age counts busy cycles elapsed.
  int m_phase = 0, m_age = 0, m_start = 0, m_to = 0;

  always @(posedge clock) begin
    if (!reset_n) begin
      m_phase = 0; m_age = 0; m_start = 0; m_to = 0;
    end else begin
      m_start = 0;
      if (m_phase == 0) begin
        if (dx_instr[31:27] == 5'd0 && (dx_instr[6:2] == 5'd6 || dx_instr[6:2] == 5'd7) && !ctrl_flush) begin
          m_phase = 1; m_age = 0; m_start = 1;
        end
      end else if (m_phase == 1) begin
        m_age++;
        if (multdiv_ready) m_phase = 2;
        else if (m_age == 40) begin m_phase = 0; m_to = 1; end
      end else begin
        m_phase = 0;
      end
    end
  end

  always @(negedge clock) begin
    int busy;
    busy = (reset_n && m_phase == 1) ? 1 : 0;
    chk("model fwd_a",   int'(fwd_a_sel),  reset_n ? m_fwd(0) : 0);
    chk("model fwd_b",   int'(fwd_b_sel),  reset_n ? m_fwd(1) : 0);
    chk("model fwd_st",  int'(fwd_st_sel), reset_n ? m_fwd(2) : 0);
    chk("model stall_front", int'(stall_front), (reset_n && (m_load_use() == 1 || busy == 1)) ? 1 : 0);
    chk("model stall_dx", int'(stall_dx), busy);
    chk("model md_busy", int'(md_busy), busy);
    chk("model multdiv_start", int'(multdiv_start), reset_n ? m_start : 0);
    chk("model md_timeout", int'(md_timeout), reset_n ? m_to : 0);
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic stages(input logic [31:0] f, input logic [31:0] d, input logic [31:0] x, input logic [31:0] m);
    fd_instr = f; dx_instr = d; xm_instr = x; mw_instr = m;
  endtask

  task automatic run_md(input logic [31:0] op_instr, input int ready_at, output int busy_n, output int starts, output int stall_bad);
    busy_n = 0; starts = 0; stall_bad = 0;
    dx_instr = op_instr;
    cyc();
    dx_instr = NOP;
    #1;
    while (md_busy && busy_n < 60) begin
      busy_n++;
      starts += int'(multdiv_start);
      if (!(stall_front && stall_dx)) stall_bad++;
      multdiv_ready = (busy_n == ready_at);
      cyc();
      multdiv_ready = 1'b0;
      #1;
    end
  endtask

  function automatic logic [31:0] rnd_instr();
    int ops [12] = '{0, 5, 8, 7, 2, 6, 4, 3, 21, 22, 1, 9};
    int regs [6] = '{0, 1, 2, 3, 30, 31};
    return ins(ops[$urandom_range(0, 11)], regs[$urandom_range(0, 5)], regs[$urandom_range(0, 5)],
               regs[$urandom_range(0, 5)], $urandom_range(0, 7));
  endfunction

  int busy_n, starts, stall_bad;
  logic [31:0] mul_i, div_i;

  initial begin
    mul_i = ins(0, 8, 1, 2, 6);
    div_i = ins(0, 9, 1, 2, 7);
    reset_n = 1'b0;
    xm_exception = 1'b0; mw_exception = 1'b0; ctrl_flush = 1'b0; multdiv_ready = 1'b0;
    stages(NOP, ins(0, 4, 3, 3, 1), ins(0, 3, 1, 2, 0), NOP);
    cyc(); #1;
    chk("reset fwd_a", int'(fwd_a_sel), 0);
    chk("reset fwd_b", int'(fwd_b_sel), 0);
    chk("reset stall_front", int'(stall_front), 0);
    chk("reset md_busy", int'(md_busy), 0);
    chk("reset md_timeout", int'(md_timeout), 0);
    cyc();
    reset_n = 1'b1;
    #1;
    chk("xm fwd_a", int'(fwd_a_sel), 1);
    chk("xm fwd_b", int'(fwd_b_sel), 1);
    cyc(); stages(NOP, ins(0, 4, 3, 3, 1), NOP, ins(0, 3, 1, 2, 0)); #1;
    chk("mw fwd_a", int'(fwd_a_sel), 2);
    chk("mw fwd_b", int'(fwd_b_sel), 2);
    cyc(); stages(NOP, ins(0, 4, 3, 3, 1), ins(0, 3, 1, 2, 0), ins(5, 3, 1, 0, 0)); #1;
    chk("xm wins fwd_a", int'(fwd_a_sel), 1);
    cyc(); stages(NOP, ins(0, 4, 3, 3, 1), ins(8, 3, 1, 0, 0), NOP); #1;
    chk("xm lw no fwd", int'(fwd_a_sel), 0);

    cyc(); stages(ins(5, 6, 5, 0, 0), ins(8, 5, 1, 0, 0), NOP, NOP); #1;
    chk("load-use stall", int'(stall_front), 1);
    chk("load-use stall_dx", int'(stall_dx), 0);
    cyc(); stages(ins(5, 6, 5, 0, 0), NOP, ins(8, 5, 1, 0, 0), NOP); #1;
    chk("load-use released", int'(stall_front), 0);
    cyc(); stages(NOP, ins(5, 6, 5, 0, 0), NOP, ins(8, 5, 1, 0, 0)); #1;
    chk("load-use then mw fwd", int'(fwd_a_sel), 2);
    cyc(); stages(ins(5, 6, 5, 0, 0), ins(8, 5, 1, 0, 0), NOP, NOP); ctrl_flush = 1'b1; #1;
    chk("load-use flushed", int'(stall_front), 0);
    cyc(); ctrl_flush = 1'b0;

    stages(NOP, ins(4, 31, 0, 0, 0), ins(3, 0, 0, 0, 0), NOP); #1;
    chk("jal->jr", int'(fwd_a_sel), 1);
    cyc(); stages(NOP, ins(22, 0, 0, 0, 0), ins(21, 0, 0, 0, 0), NOP); #1;
    chk("setx->bex", int'(fwd_a_sel), 1);
    cyc(); stages(NOP, ins(22, 0, 0, 0, 0), NOP, NOP); xm_exception = 1'b1; #1;
    chk("exception->bex", int'(fwd_a_sel), 1);
    cyc(); xm_exception = 1'b0; stages(NOP, ins(7, 7, 1, 0, 0), ins(0, 7, 2, 3, 0), NOP); #1;
    chk("sw store fwd", int'(fwd_st_sel), 1);
    chk("sw base no fwd", int'(fwd_a_sel), 0);

    cyc(); stages(NOP, NOP, NOP, NOP);
    run_md(mul_i, 17, busy_n, starts, stall_bad);
    chk("mul busy cycles", busy_n, 17);
    chk("mul start pulses", starts, 1);
    chk("mul stalls held", stall_bad, 0);
    chk("mul done stall", int'(stall_front), 0);
    chk("mul done start", int'(multdiv_start), 0);
    cyc(); #1;
    chk("mul idle busy", int'(md_busy), 0);

    run_md(div_i, 0, busy_n, starts, stall_bad);
    chk("div timeout cycles", busy_n, 40);
    chk("div timeout flag", int'(md_timeout), 1);
    chk("div timeout stall", int'(stall_front), 0);
    repeat (3) cyc();
    #1;
    chk("timeout sticky", int'(md_timeout), 1);

    reset_n = 1'b0; cyc(); cyc(); reset_n = 1'b1; #1;
    chk("timeout cleared", int'(md_timeout), 0);
    run_md(div_i, 40, busy_n, starts, stall_bad);
    chk("ready on timeout cycles", busy_n, 40);
    chk("ready on timeout flag", int'(md_timeout), 0);

    cyc(); dx_instr = mul_i; cyc();
    stages(NOP, ins(0, 4, 3, 3, 1), ins(0, 3, 1, 2, 0), NOP);
    repeat (5) cyc();
    #1;
    reset_n = 1'b0; #1;
    chk("mid-reset md_busy", int'(md_busy), 0);
    chk("mid-reset stall_front", int'(stall_front), 0);
    chk("mid-reset stall_dx", int'(stall_dx), 0);
    chk("mid-reset fwd_a", int'(fwd_a_sel), 0);
    cyc(); cyc(); reset_n = 1'b1; stages(NOP, NOP, NOP, NOP); #1;
    chk("post-reset idle", int'(md_busy), 0);
    run_md(mul_i, 5, busy_n, starts, stall_bad);
    chk("post-reset mul start", starts, 1);
    chk("post-reset mul cycles", busy_n, 5);

    for (int c = 0; c < 2000; c++) begin
      cyc();
      reset_n       = ($urandom_range(0, 299) != 0);
      fd_instr      = rnd_instr();
      dx_instr      = rnd_instr();
      xm_instr      = rnd_instr();
      mw_instr      = rnd_instr();
      xm_exception  = ($urandom_range(0, 9) == 0);
      mw_exception  = ($urandom_range(0, 9) == 0);
      ctrl_flush    = ($urandom_range(0, 7) == 0);
      multdiv_ready = ($urandom_range(0, 11) == 0);
    end
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
Parametrised successor to the combinational bypass-select logic in the 5-stage pipeline. It produces per-operand forwarding selects for both ALU operands and the store-data path, covering the rd→$r31 (jal), setx/bex and exception→$r30 cases. It adds two kinds of sequential hazard control: a one-cycle load-use stall, and a mult/div busy FSM with start pulse, stall and timeout. It sits beside the F/D, D/X, X/M and M/W latches and drives their enables and the D/X bubble insertion.

Parameters:
REG_W, 5, register index width
LINK_REG, 31, jal destination index
STATUS_REG, 30, setx/exception destination index
MD_TIMEOUT, 40, max BUSY cycles before abort
CNT_W, 6, busy counter width; must satisfy 2^CNT_W > MD_TIMEOUT

Ports:
clock  in  1  pipeline clock
reset_n  in  1  asynchronous active-low reset
fd_instr, dx_instr, xm_instr, mw_instr  in  32 each  latched instructions
xm_exception, mw_exception  in  1 each  instruction in that stage writes STATUS_REG
ctrl_flush  in  1  taken branch/jump; F/D and D/X are being squashed this cycle
multdiv_ready  in  1  mult/div result valid
multdiv_start  out  1  one-cycle start pulse to mult/div unit
stall_front  out  1  hold PC and F/D; bubble into D/X
stall_dx  out  1  hold D/X; bubble into X/M
fwd_a_sel, fwd_b_sel, fwd_st_sel  out  2 each  00 regfile, 01 X/M, 10 M/W
md_busy  out  1  FSM in BUSY
md_timeout  out  1  sticky abort flag

Behaviour:
- Reset: FSM=IDLE, counter=0, md_timeout=0. Every output is 0 during and after reset. Reset mid-BUSY discards the operation.
- Fields: op[31:27], rd[26:22], rs[21:17], rt[16:12], aluop[6:2].
- Destinations:
  - R-type (op 0), addi (5), lw (8): rd.
  - jal (3): LINK_REG.
  - setx (21): STATUS_REG.
  - A stage with its exception input set: STATUS_REG.
  - All other ops: none.
  - Index 0 is never a destination.
- Sources (A/B/store):
  - R: rs/rt/–
  - addi, lw: rs/–/–
  - sw (7): rs/–/rd
  - bne (2), blt (6): rd/rs/–
  - jr (4): rd/–/–
  - bex (22): STATUS_REG/–/–
  - A source equal to 0 never forwards.
- Forwarding (combinational, from DX sources): X/M match wins over M/W match, otherwise 00. An X/M-stage lw never matches (covered by the stall).
- Load-use stall: stall_front=1 for exactly one cycle when dx is lw with rd≠0 and any fd source equals dx rd. Suppressed when ctrl_flush=1.
- Mult/div: dx is R-type with aluop 6 (mul) or 7 (div).
- FSM:
  - IDLE: on a DX mult/div with ctrl_flush=0, assert multdiv_start (one cycle) and go to BUSY. multdiv_ready is ignored in IDLE.
  - BUSY: md_busy=1, stall_front=1, stall_dx=1, counter increments each cycle.
    - On multdiv_ready: go to DONE.
    - Else, when counter==MD_TIMEOUT-1: set md_timeout (sticky until reset) and go to IDLE.
    - multdiv_ready in the same cycle as the timeout takes precedence.
  - DONE: one cycle, stalls released, counter cleared, result advances to X/M. Go to IDLE, where the next DX op (not the same mult/div) is evaluated.
- ctrl_flush in BUSY is ignored, because the branch cannot reside in DX.
- Stall OR: stall_front = load_use | BUSY. stall_dx = BUSY only.

Decomposition:
- Package hazard_pkg: opcode constants (OP_ALU, OP_ADDI, OP_LW, OP_SW, OP_BNE, OP_BLT, OP_JR, OP_JAL, OP_SETX, OP_BEX), ALU_MUL/ALU_DIV, fwd-select encodings, FSM state typedef.
- Sub-module instr_operand_decode: instr + exception → dest_valid, dest, src_a/b/st valid+index. Instantiated once per stage (4 instances).

Test Plan:
- add r3←r1,r2 followed by sub r4←r3,r3 → fwd_a_sel=fwd_b_sel=01 for one cycle; two apart → 10; the X/M copy wins when both stages write r3.
- lw r5 followed by addi r6←r5 → stall_front=1 for exactly 1 cycle, then fwd_a_sel=10; the same pattern with ctrl_flush=1 → no stall.
- jal followed by jr r31 → fwd_a_sel=01. setx followed by bex → 01. xm_exception=1 with bex in DX → 01.
- mul in DX, multdiv_ready after 17 cycles → one multdiv_start pulse, stall_front=stall_dx=md_busy=1 for 17 cycles, then DONE for 1 cycle, then IDLE.
- div with ready never asserted → md_timeout rises after MD_TIMEOUT cycles and stays high, stalls drop. Ready arriving on the timeout cycle → DONE, md_timeout=0.
- reset_n low mid-BUSY → all outputs 0 immediately; after release, FSM=IDLE and a new mul pulses multdiv_start.
